lfsr_rand_server: RTL and testbench

Shared random-number server that owns one 32-bit maximal-length LFSR (x^32 + x^30 + x^11 + x^5 + 1) and time-multiplexes it among N_REQ consumers, such as TLB random-index replacement, cache victim-way selection and predictor tie-breaking. A round-robin arbiter grants at most one requester per cycle. A warm-up sequencer and a reseed port control the generator state. Every grant returns a distinct LFSR state and advances the generator, so no two consumers ever receive the same draw.

---
 rtl/lfsr_rand_server.sv | 144 ++++++++++++++
 tb/tb_lfsr_rand_server.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_server.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_rand_server
// Brief    : Round-robin shared server handing out distinct 32-bit LFSR draws.
// Revision : 1.0
// ============================================================================
module lfsr_rand_server #(
    parameter int          N_REQ  = 4,
    parameter int          OUT_W  = 32,
    parameter logic [31:0] SEED   = 32'hdeadface,
    parameter int          WARMUP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [OUT_W-1:0] rnd_o,
    input  logic             seed_valid_i,
    input  logic [31:0]      seed_data_i,
    input  logic             free_run_i,
    output logic             ready_o
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_RST  = c_CNT_W'(WARMUP);

    typedef enum logic [0:0] {
        S_WARMUP = 1'b0,
        S_READY  = 1'b1
    } state_t;

    localparam state_t c_START = (WARMUP == 0) ? S_READY : S_WARMUP;

    state_t             r_state;
    logic [31:0]        r_lfsr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_last_gnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [OUT_W-1:0]   r_rnd;

    state_t             w_state_nxt;
    logic [31:0]        w_lfsr_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] w_last_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [OUT_W-1:0]   w_rnd_nxt;

    logic [N_REQ-1:0]   w_elig;
    logic               w_found;
    logic [c_IDX_W-1:0] w_win_idx;
    logic [N_REQ-1:0]   w_win_oh;
    logic [c_IDX_W-1:0] w_sel;
    int                 w_pos;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[0] ^ s[2] ^ s[21] ^ s[27], s[31:1]};
    endfunction

    // Last cycle's grant is masked so a requester still dropping req is not re-granted.
    always_comb begin
        w_elig    = req_i & ~r_gnt;
        w_found   = 1'b0;
        w_win_idx = r_last_gnt;
        w_win_oh  = '0;
        w_sel     = '0;
        w_pos     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_pos = int'(r_last_gnt) + i;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            w_sel = c_IDX_W'(w_pos);
            if (!w_found && w_elig[w_sel]) begin
                w_found         = 1'b1;
                w_win_idx       = w_sel;
                w_win_oh[w_sel] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_gnt;
        w_gnt_nxt   = '0;
        w_rnd_nxt   = r_rnd;
        if (seed_valid_i) begin
            // A zero seed would lock the LFSR, so it falls back to SEED.
            w_lfsr_nxt  = (seed_data_i == 32'h0) ? SEED : seed_data_i;
            w_cnt_nxt   = c_CNT_RST;
            w_state_nxt = c_START;
        end else begin
            case (r_state)
                S_WARMUP: begin
                    w_lfsr_nxt = lfsr_step(r_lfsr);
                    w_cnt_nxt  = r_cnt - c_CNT_W'(1);
                    if (r_cnt <= c_CNT_W'(1)) begin
                        w_state_nxt = S_READY;
                    end
                end
                S_READY: begin
                    if (w_found) begin
                        w_gnt_nxt  = w_win_oh;
                        w_rnd_nxt  = r_lfsr[OUT_W-1:0];
                        w_lfsr_nxt = lfsr_step(r_lfsr);
                        w_last_nxt = w_win_idx;
                    end else if (free_run_i) begin
                        w_lfsr_nxt = lfsr_step(r_lfsr);
                    end
                end
                default: begin
                    w_state_nxt = c_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_START;
            r_lfsr     <= SEED;
            r_cnt      <= c_CNT_RST;
            r_last_gnt <= c_LAST_RST;
            r_gnt      <= '0;
            r_rnd      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_gnt <= w_last_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rnd      <= w_rnd_nxt;
        end
    end

    assign gnt_o   = r_gnt;
    assign rnd_o   = r_rnd;
    assign ready_o = (r_state == S_READY);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rand_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_rand_server
// Brief    : Directed bench for lfsr_rand_server, WARMUP=0 and WARMUP=16 builds.
// Revision : 1.0
// ============================================================================
module tb_lfsr_rand_server;

    localparam logic [31:0] c_SEED = 32'hdeadface;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with no warm-up
    logic        rst0_n, seed_v0, fr0, rdy0;
    logic [3:0]  req0, gnt0;
    logic [31:0] seed_d0, rnd0;

    // Instance with a 16-cycle warm-up
    logic        rst16_n, seed_v16, fr16, rdy16;
    logic [3:0]  req16, gnt16;
    logic [31:0] seed_d16, rnd16;

    lfsr_rand_server #(.N_REQ(4), .OUT_W(32), .SEED(c_SEED), .WARMUP(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .req_i(req0), .gnt_o(gnt0), .rnd_o(rnd0),
        .seed_valid_i(seed_v0), .seed_data_i(seed_d0), .free_run_i(fr0), .ready_o(rdy0)
    );

    lfsr_rand_server #(.N_REQ(4), .OUT_W(32), .SEED(c_SEED), .WARMUP(16)) u_dut16 (
        .clk(clk), .rst_n(rst16_n), .req_i(req16), .gnt_o(gnt16), .rnd_o(rnd16),
        .seed_valid_i(seed_v16), .seed_data_i(seed_d16), .free_run_i(fr16), .ready_o(rdy16)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[0] ^ s[2] ^ s[21] ^ s[27], s[31:1]};
    endfunction

    function automatic logic [31:0] ref_stepn(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = ref_step(v);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut0();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
    endtask

    logic [31:0] m_lfsr;
    logic [31:0] m_last;

    initial begin
        rst0_n = 1'b0; req0 = '0; seed_v0 = 1'b0; seed_d0 = '0; fr0 = 1'b0;
        rst16_n = 1'b0; req16 = '0; seed_v16 = 1'b0; seed_d16 = '0; fr16 = 1'b0;
        tick();
        tick();

        chk("rst_gnt0", 32'(gnt0), 32'h0);
        chk("rst_rnd0", rnd0, 32'h0);
        chk("rst_rdy0", 32'(rdy0), 32'h1);
        chk("rst_gnt16", 32'(gnt16), 32'h0);
        chk("rst_rnd16", rnd16, 32'h0);
        chk("rst_rdy16", 32'(rdy16), 32'h0);

        // First draws; idle cycles without free_run must not advance the LFSR
        rst0_n = 1'b1;
        tick();
        tick();
        req0 = 4'b0001;
        tick();
        chk("first_gnt", 32'(gnt0), 32'h1);
        chk("first_rnd", rnd0, 32'hdeadface);
        tick();
        chk("first_gap", 32'(gnt0), 32'h0);
        tick();
        chk("second_gnt", 32'(gnt0), 32'h1);
        chk("second_rnd", rnd0, 32'hef56fd67);
        req0 = 4'b0000;

        // Round robin across all four requesters
        reset_dut0();
        req0 = 4'b1111;
        m_lfsr = c_SEED;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt0), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr_rnd%0d", k), rnd0, m_lfsr);
            m_lfsr = ref_step(m_lfsr);
        end
        req0 = 4'b0000;

        // Lone held requester is granted every other cycle; rnd holds in gaps
        reset_dut0();
        req0 = 4'b0100;
        m_lfsr = c_SEED;
        m_last = 32'h0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k % 2 == 0) begin
                chk($sformatf("mask_gnt%0d", k), 32'(gnt0), 32'h4);
                chk($sformatf("mask_rnd%0d", k), rnd0, m_lfsr);
                m_last = m_lfsr;
                m_lfsr = ref_step(m_lfsr);
            end else begin
                chk($sformatf("mask_gnt%0d", k), 32'(gnt0), 32'h0);
                chk($sformatf("mask_hold%0d", k), rnd0, m_last);
            end
        end
        req0 = 4'b0000;

        // Free-running for three idle cycles, then one grant
        reset_dut0();
        fr0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fr_idle%0d", k), 32'(gnt0), 32'h0);
        end
        fr0 = 1'b0;
        req0 = 4'b0001;
        tick();
        chk("fr_gnt", 32'(gnt0), 32'h1);
        chk("fr_rnd", rnd0, ref_stepn(c_SEED, 3));
        req0 = 4'b0000;

        // Nonzero reseed concurrent with a request
        reset_dut0();
        seed_v0 = 1'b1;
        seed_d0 = 32'h12345678;
        req0 = 4'b0001;
        tick();
        chk("rs_nogrant", 32'(gnt0), 32'h0);
        chk("rs_ready", 32'(rdy0), 32'h1);
        seed_v0 = 1'b0;
        seed_d0 = '0;
        tick();
        chk("rs_gnt", 32'(gnt0), 32'h1);
        chk("rs_rnd", rnd0, 32'h12345678);
        tick();
        tick();
        chk("rs_rnd2", rnd0, ref_step(32'h12345678));
        req0 = 4'b0000;

        // Asynchronous reset while a grant is visible
        reset_dut0();
        req0 = 4'b0011;
        tick();
        chk("mid_gnt", 32'(gnt0), 32'h1);
        rst0_n = 1'b0;
        #1;
        chk("mid_async_gnt", 32'(gnt0), 32'h0);
        tick();
        rst0_n = 1'b1;
        req0 = 4'b0001;
        tick();
        chk("mid_regnt", 32'(gnt0), 32'h1);
        chk("mid_seed", rnd0, c_SEED);
        req0 = 4'b0000;

        // Warm-up of 16 steps with a request held from reset
        req16 = 4'b0010;
        rst16_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("wu_rdy%0d", i), 32'(rdy16), (i == 16) ? 32'h1 : 32'h0);
            chk($sformatf("wu_gnt%0d", i), 32'(gnt16), 32'h0);
        end
        tick();
        chk("wu_first_gnt", 32'(gnt16), 32'h2);
        chk("wu_first_rnd", rnd16, ref_stepn(c_SEED, 16));

        // Zero reseed with a request pending: falls back to SEED and warms up again
        req16 = 4'b0001;
        seed_v16 = 1'b1;
        seed_d16 = 32'h0;
        tick();
        chk("rz_nogrant", 32'(gnt16), 32'h0);
        chk("rz_rdy", 32'(rdy16), 32'h0);
        seed_v16 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("rz_rdy%0d", i), 32'(rdy16), (i == 16) ? 32'h1 : 32'h0);
            chk($sformatf("rz_gnt%0d", i), 32'(gnt16), 32'h0);
        end
        tick();
        chk("rz_gnt", 32'(gnt16), 32'h1);
        chk("rz_rnd", rnd16, ref_stepn(c_SEED, 16));
        req16 = 4'b0000;

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
